pool2d_stream: RTL and testbench
================================

// Module: pool2d_stream
// PURPOSE
//  Parametrised 2x2/stride-2 pooling stage for the conv pipeline; successor to the fixed max_pool stage.
//  Consumes conv output features in raster order, all channels in parallel, one pixel per valid cycle.
//  Emits one pooled pixel per 2x2 window in MAX or AVG mode, with end-of-frame marker.
//  Sits between conv and post_processing; input may have bubbles, no backpressure.
// PARAMETERS
//  DATA_WIDTH    16  signed feature width, in and out
//  NUM_CHANNELS  6   parallel channels per pixel
//  NUM_COLUMNS   28  input columns per row; must be even (elaboration-time assertion)
//  NUM_ROWS      28  input rows per frame; must be even (elaboration-time assertion)
//  POOL_MODE     0   0 = max, 1 = average (pool_mode_e)
// PORTS
//  i_clk       in   1                        clock
//  i_rst_n     in   1                        asynchronous reset, active low
//  i_valid     in   1                        i_features holds a valid pixel this cycle
//  i_features  in   NUM_CHANNELS*DATA_WIDTH  signed features, unpacked array [NUM_CHANNELS]
//  i_flush     in   1                        synchronous frame abort; clears position counters
//  o_valid     out  1                        o_features holds a pooled pixel (1-cycle pulse)
//  o_features  out  NUM_CHANNELS*DATA_WIDTH  pooled signed features
//  o_last      out  1                        high with o_valid on the last pooled pixel of a frame
// BEHAVIOUR
//  Reset: o_valid=0, o_last=0, o_features=0, col/row counters=0, line buffer contents don't-care.
//  Reset mid-frame: partial frame discarded; next i_valid pixel is row 0, col 0.
//  Counters: col 0..NUM_COLUMNS-1 advances on i_valid; wrap to 0 increments row; row wraps at NUM_ROWS.
//  Even col: register pixel as horizontal partner (hreg) per channel.
//  Odd col, even row: write hcomb(hreg, pixel) to line buffer slot col>>1.
//  Odd col, odd row: result = vcomb(linebuf[col>>1], hcomb(hreg, pixel)); registered to o_features.
//  Latency: o_valid asserts exactly 1 cycle after the accepting odd-row/odd-col i_valid cycle.
//  o_last asserts with the output for row NUM_ROWS-1, col NUM_COLUMNS-1; counters already at 0.
//  MAX: hcomb/vcomb = signed max; width DATA_WIDTH throughout.
//  AVG: hcomb = signed sum, DATA_WIDTH+1; vcomb = sum of pair sums, DATA_WIDTH+2;
//   result = (sum + 2) >>> 2 (round half up), truncated to DATA_WIDTH; always in range, no saturation.
//  Bubbles: i_valid low holds all state; output sequence is independent of bubble pattern.
//  i_flush: counters -> 0 next cycle, o_valid/o_last forced 0 that cycle; flush wins over
//   simultaneous i_valid (pixel dropped). Output already registered on the flush cycle stays valid.
//  Back-to-back frames: row 0 col 0 of next frame may arrive the cycle after the last pixel.
//  Line buffer depth NUM_COLUMNS/2, width NUM_CHANNELS*(DATA_WIDTH+1); written once, read once per slot/frame row pair.
// STRUCTURE
//  cnn_pkg: feature_t (logic signed [DATA_WIDTH-1:0]), pool_mode_e {POOL_MAX, POOL_AVG}.
//  Sub-module pool_line_buffer: 1W/1R register array, depth/width parametrised, read-during-write
//   returns old data; instantiated once for all channels.
//  Per-channel combine logic in a generate loop; single shared col/row counter.
// TESTING
//  1 MAX, 4x4, 1 ch, ramp 0..15 raster -> outputs 5,7,13,15; o_last on 4th; each 1 cycle after pixels 5,7,13,15.
//  2 AVG, same ramp -> outputs 3,5,11,13.
//  3 AVG extremes, DATA_WIDTH=16: all -32768 -> -32768; all 32767 -> 32767; MAX window {-32768,-1,-5,-2} -> -1.
//  4 28x28x6, random i_valid bubbles (50%) vs no bubbles -> identical 196-pixel output sequences, one o_last.
//  5 i_rst_n low after 30 pixels, then full frame -> only 196 correct outputs; all outputs 0 during reset.
//  6 i_flush with i_valid mid-row 3, then two back-to-back frames -> no stale output, 2x196 outputs, two o_last.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the conv pipeline stages.
package cnn_pkg;

  localparam int unsigned FEATURE_WIDTH = 16;

  typedef logic signed [FEATURE_WIDTH-1:0] feature_t;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_e;

  // Address/counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Single write / single read register array holding the pooled row pairs.
// Reads are combinational, so a read of the slot being written returns the old word.
module pool_line_buffer
  import cnn_pkg::*;
#(
  parameter int unsigned DEPTH  = 14,
  parameter int unsigned WIDTH  = 102,
  localparam int unsigned ADDR_W = clog2_min1(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write; contents need no reset because every slot is written before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/pool2d_stream.sv
// 2x2 stride-2 pooling over a raster pixel stream, all channels in parallel.
// Even rows store the horizontal pair result per column pair; odd rows combine it
// with the current pair and emit one pooled pixel.
module pool2d_stream
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_CHANNELS = 6,
  parameter int unsigned NUM_COLUMNS  = 28,
  parameter int unsigned NUM_ROWS     = 28,
  parameter pool_mode_e  POOL_MODE    = POOL_MAX
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_features [NUM_CHANNELS],
  input  logic                         i_flush,
  output logic                         o_valid,
  output logic signed [DATA_WIDTH-1:0] o_features [NUM_CHANNELS],
  output logic                         o_last
);

  localparam int unsigned COL_W     = clog2_min1(NUM_COLUMNS);
  localparam int unsigned ROW_W     = clog2_min1(NUM_ROWS);
  localparam int unsigned LB_DEPTH  = NUM_COLUMNS / 2;
  localparam int unsigned LB_ADDR_W = clog2_min1(LB_DEPTH);
  localparam int unsigned HW        = DATA_WIDTH + 1;
  localparam int unsigned VW        = DATA_WIDTH + 2;
  localparam int unsigned LB_W      = NUM_CHANNELS * HW;

  // Frame geometry must tile exactly into 2x2 windows.
  if ((NUM_COLUMNS % 2) != 0 || NUM_COLUMNS < 2) begin : g_bad_columns
    $error("pool2d_stream: NUM_COLUMNS must be even and at least 2");
  end
  if ((NUM_ROWS % 2) != 0 || NUM_ROWS < 2) begin : g_bad_rows
    $error("pool2d_stream: NUM_ROWS must be even and at least 2");
  end

  logic [COL_W-1:0]             col_q;
  logic [ROW_W-1:0]             row_q;
  logic signed [DATA_WIDTH-1:0] hreg_q [NUM_CHANNELS];

  logic                         accept;
  logic                         col_odd;
  logic                         row_odd;
  logic                         col_last;
  logic                         row_last;
  logic [LB_ADDR_W-1:0]         lb_addr;
  logic                         lb_wr_en;
  logic [LB_W-1:0]              lb_wr_data;
  logic [LB_W-1:0]              lb_rd_data;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] res_flat;

  assign accept   = i_valid & ~i_flush;
  assign col_odd  = col_q[0];
  assign row_odd  = row_q[0];
  assign col_last = (col_q == COL_W'(NUM_COLUMNS - 1));
  assign row_last = (row_q == ROW_W'(NUM_ROWS - 1));
  assign lb_addr  = LB_ADDR_W'(col_q >> 1);
  assign lb_wr_en = accept & col_odd & ~row_odd;

  pool_line_buffer #(
    .DEPTH (LB_DEPTH),
    .WIDTH (LB_W)
  ) u_line_buffer (
    .clk     (i_clk),
    .wr_en   (lb_wr_en),
    .wr_addr (lb_addr),
    .wr_data (lb_wr_data),
    .rd_addr (lb_addr),
    .rd_data (lb_rd_data)
  );

  // Per-channel horizontal and vertical combine.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] px;
    logic signed [DATA_WIDTH-1:0] hr;
    logic signed [HW-1:0]         hcomb;
    logic signed [HW-1:0]         lb_h;
    logic signed [DATA_WIDTH-1:0] res;

    assign px   = i_features[c];
    assign hr   = hreg_q[c];
    assign lb_h = lb_rd_data[c*HW +: HW];

    if (POOL_MODE == POOL_MAX) begin : g_max
      // Max values stay in DATA_WIDTH; the extra buffer bit is just sign extension.
      logic signed [DATA_WIDTH-1:0] hmax;
      assign hmax  = (px > hr) ? px : hr;
      assign hcomb = HW'(hmax);
      assign res   = (lb_h > hcomb) ? DATA_WIDTH'(lb_h) : hmax;
    end else begin : g_avg
      // Four-pixel sum plus 2, arithmetic shift by 2: rounds half up, always fits DATA_WIDTH.
      assign hcomb = HW'(hr) + HW'(px);
      assign res   = DATA_WIDTH'((VW'(lb_h) + VW'(hcomb) + VW'(2)) >>> 2);
    end

    assign lb_wr_data[c*HW +: HW]             = hcomb;
    assign res_flat[c*DATA_WIDTH +: DATA_WIDTH] = res;
  end

  // Horizontal partner capture on even columns.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        hreg_q[c] <= '0;
      end
    end else if (accept && !col_odd) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        hreg_q[c] <= i_features[c];
      end
    end
  end

  // Raster position counters and registered pooled output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        o_features[c] <= '0;
      end
    end else begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      if (i_flush) begin
        col_q <= '0;
        row_q <= '0;
      end else if (i_valid) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
        if (col_odd && row_odd) begin
          o_valid <= 1'b1;
          o_last  <= row_last & col_last;
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            o_features[c] <= res_flat[c*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream: 4x4 single-channel MAX/AVG instances with
// hand-computed results, and a 28x28x6 AVG instance checked against a window model.
module tb_pool2d_stream;
  import cnn_pkg::*;

  localparam int unsigned DW  = 16;
  localparam int unsigned BC  = 28;
  localparam int unsigned BR  = 28;
  localparam int unsigned BCH = 6;
  localparam int unsigned BN  = BC * BR;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Small 4x4x1 instances share one input stream.
  logic                 s_valid = 1'b0;
  logic                 s_flush = 1'b0;
  logic signed [DW-1:0] s_feat [1];
  logic                 sm_valid, sm_last, sa_valid, sa_last;
  logic signed [DW-1:0] sm_feat [1];
  logic signed [DW-1:0] sa_feat [1];

  // Full-size AVG instance.
  logic                 b_valid = 1'b0;
  logic                 b_flush = 1'b0;
  logic signed [DW-1:0] b_feat  [BCH];
  logic                 bo_valid, bo_last;
  logic signed [DW-1:0] bo_feat [BCH];

  pool2d_stream #(.DATA_WIDTH(DW), .NUM_CHANNELS(1), .NUM_COLUMNS(4), .NUM_ROWS(4),
                  .POOL_MODE(POOL_MAX)) u_small_max (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .i_features(s_feat), .i_flush(s_flush),
    .o_valid(sm_valid), .o_features(sm_feat), .o_last(sm_last));

  pool2d_stream #(.DATA_WIDTH(DW), .NUM_CHANNELS(1), .NUM_COLUMNS(4), .NUM_ROWS(4),
                  .POOL_MODE(POOL_AVG)) u_small_avg (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(s_valid), .i_features(s_feat), .i_flush(s_flush),
    .o_valid(sa_valid), .o_features(sa_feat), .o_last(sa_last));

  pool2d_stream #(.DATA_WIDTH(DW), .NUM_CHANNELS(BCH), .NUM_COLUMNS(BC), .NUM_ROWS(BR),
                  .POOL_MODE(POOL_AVG)) u_big (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .i_features(b_feat), .i_flush(b_flush),
    .o_valid(bo_valid), .o_features(bo_feat), .o_last(bo_last));

  int n_checks = 0;
  int n_errors = 0;
  int stray_last = 0;

  logic signed [DW-1:0] frm [2][BN][BCH];
  logic [127:0]         exp_q [$];
  logic [127:0]         got_q [$];
  logic [127:0]         mon_g;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every pooled pixel of the big instance as {last, ch5..ch0}.
  always @(negedge clk) begin
    if (bo_valid) begin
      mon_g = '0;
      for (int c = 0; c < BCH; c++) mon_g[c*DW +: DW] = bo_feat[c];
      mon_g[BCH*DW] = bo_last;
      got_q.push_back(mon_g);
    end
    if (bo_last && !bo_valid) stray_last++;
  end

  task automatic small_frame(input string nm, input int px [16], input int emax [4],
                             input int eavg [4]);
    int k;
    k = 0;
    for (int p = 0; p < 16; p++) begin
      s_valid   = 1'b1;
      s_feat[0] = DW'(px[p]);
      @(negedge clk);
      if (((p / 4) % 2 == 1) && (p % 2 == 1)) begin
        chk($sformatf("%s_max_valid_p%0d", nm, p), sm_valid, 1'b1);
        chk($sformatf("%s_max_val%0d", nm, k), sm_feat[0], emax[k]);
        chk($sformatf("%s_max_last_p%0d", nm, p), sm_last, (p == 15));
        chk($sformatf("%s_avg_valid_p%0d", nm, p), sa_valid, 1'b1);
        chk($sformatf("%s_avg_val%0d", nm, k), sa_feat[0], eavg[k]);
        chk($sformatf("%s_avg_last_p%0d", nm, p), sa_last, (p == 15));
        k++;
      end else begin
        chk($sformatf("%s_idle_p%0d", nm, p), {sm_valid, sa_valid, sm_last, sa_last}, 4'b0000);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic gen_frame(input int f);
    int r;
    for (int p = 0; p < BN; p++) begin
      for (int c = 0; c < BCH; c++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      frm[f][p][c] = -16'sd32768;
        else if (r == 1) frm[f][p][c] = 16'sd32767;
        else             frm[f][p][c] = DW'($urandom);
      end
    end
  endtask

  task automatic send_pixel_b(input int f, input int p, input bit flush);
    b_valid = 1'b1;
    b_flush = flush;
    for (int c = 0; c < BCH; c++) b_feat[c] = frm[f][p][c];
    @(negedge clk);
    b_valid = 1'b0;
    b_flush = 1'b0;
  endtask

  task automatic send_frame_b(input int f, input bit bubbles);
    for (int p = 0; p < BN; p++) begin
      if (bubbles) begin
        for (int i = 0; i < 8; i++) begin
          if ($urandom_range(0, 1) == 0) break;
          @(negedge clk);
        end
      end
      send_pixel_b(f, p, 1'b0);
    end
  endtask

  // Reference: average of each 2x2 window, rounded half up.
  task automatic expect_frame(input int f);
    logic [127:0] e;
    int s;
    int a;
    for (int r = 0; r < BR; r += 2) begin
      for (int cc = 0; cc < BC; cc += 2) begin
        e = '0;
        for (int ch = 0; ch < BCH; ch++) begin
          s = int'(frm[f][r*BC+cc][ch]) + int'(frm[f][r*BC+cc+1][ch])
            + int'(frm[f][(r+1)*BC+cc][ch]) + int'(frm[f][(r+1)*BC+cc+1][ch]);
          a = (s + 2) >>> 2;
          e[ch*DW +: DW] = DW'(a);
        end
        e[BCH*DW] = (r == BR - 2) && (cc == BC - 2);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic compare_big(input string nm);
    chk({nm, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_px%0d", nm, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_outputs_zero(input string nm);
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < BCH; c++) v[c*DW +: DW] = bo_feat[c];
    chk({nm, "_big_ctrl"}, {bo_valid, bo_last}, 2'b00);
    chk({nm, "_big_feat"}, v, 128'd0);
    chk({nm, "_small"}, {sm_valid, sm_last, sa_valid, sa_last, sm_feat[0], sa_feat[0]}, 36'd0);
  endtask

  int ramp [16];
  int lo   [16];
  int hi   [16];
  int win  [16];

  initial begin
    s_feat[0] = '0;
    for (int c = 0; c < BCH; c++) b_feat[c] = '0;
    for (int p = 0; p < 16; p++) begin
      ramp[p] = p;
      lo[p]   = -32768;
      hi[p]   = 32767;
      win[p]  = 0;
    end
    win[0] = -32768; win[1] = -1; win[4] = -5; win[5] = -2;

    // Reset state
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp in MAX and AVG, plus extremes
    small_frame("ramp", ramp, '{5, 7, 13, 15}, '{3, 5, 11, 13});
    small_frame("allmin", lo, '{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768});
    small_frame("allmax", hi, '{32767, 32767, 32767, 32767}, '{32767, 32767, 32767, 32767});
    small_frame("window", win, '{-1, 0, 0, 0}, '{-8194, 0, 0, 0});

    // Full frame without and with input bubbles
    gen_frame(0);
    send_frame_b(0, 1'b0);
    repeat (3) @(negedge clk);
    expect_frame(0);
    compare_big("nobubble");
    send_frame_b(0, 1'b1);
    repeat (3) @(negedge clk);
    expect_frame(0);
    compare_big("bubble");

    // Reset mid-frame, then a full frame
    gen_frame(1);
    for (int p = 0; p < 30; p++) send_pixel_b(1, p, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midreset0");
    @(negedge clk);
    chk_outputs_zero("midreset1");
    got_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    send_frame_b(1, 1'b0);
    repeat (3) @(negedge clk);
    expect_frame(1);
    compare_big("after_reset");

    // Flush mid-row 3 on an odd/odd pixel, then back-to-back frames
    gen_frame(0);
    for (int p = 0; p < 3 * BC + 10; p++) send_pixel_b(0, p, 1'b0);
    chk("preflush_valid", bo_valid, 1'b1);
    send_pixel_b(0, 3 * BC + 10, 1'b0);
    send_pixel_b(0, 3 * BC + 11, 1'b1);
    chk("flush_no_output", {bo_valid, bo_last}, 2'b00);
    repeat (2) @(negedge clk);
    got_q.delete();
    gen_frame(1);
    send_frame_b(0, 1'b0);
    send_frame_b(1, 1'b0);
    repeat (3) @(negedge clk);
    expect_frame(0);
    expect_frame(1);
    compare_big("b2b");

    chk("stray_last", stray_last, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
